// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
//   rx_state_e : frame-sequencer state encoding (3-bit)
//   MID_OFS    : offset added to prescale/2 to get the in-bit sample edge
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    // The sampler takes three samples centred on prescale/2; its majority
    // vote is settled two edges later.
    localparam int MID_OFS = 2;

endpackage

// File: rtl/uart_edge_bit_cnt.sv
// Oversample edge counter and data bit counter for the UART receiver.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : synchronous clear of both counters (highest priority)
//   edge_run    : advance edge_cnt this cycle
//   edge_last   : edge_cnt is at the last edge of the bit; wrap to 0
//   bit_clr     : clear bit_cnt
//   bit_inc     : advance bit_cnt
//   edge_cnt    : oversample edge index within the current bit
//   bit_cnt     : data bit index
module uart_edge_bit_cnt #(
    parameter int PRESC_W = 6,
    parameter int BIT_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               edge_run,
    input  logic               edge_last,
    input  logic               bit_clr,
    input  logic               bit_inc,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic [BIT_W-1:0]   bit_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (clr) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            if (edge_run)
                edge_cnt <= edge_last ? '0 : edge_cnt + PRESC_W'(1);
            if (bit_clr)
                bit_cnt <= '0;
            else if (bit_inc)
                bit_cnt <= bit_cnt + BIT_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Frame-sequencing FSM for the UART receiver. Walks START/DATA/PARITY/STOP,
// drives the oversampling counters, strobes the checkers at the mid-bit edge
// and pulses data_valid once for every frame that passes its checks.
//   clk, rst_n    : clock, asynchronous active-low reset
//   EN            : receiver enable, low clears the sequencer synchronously
//   rx_in         : synchronised serial line (idle high)
//   prescale      : oversample ratio (8/16/32), captured at frame start
//   par_en        : frame has a parity bit
//   strt_glitch   : start checker flag (start bit sampled high)
//   par_err       : parity checker flag
//   stop_err      : stop checker flag
//   data_samp_en  : sampler enable, high outside IDLE
//   edge_cnt      : edge index within the bit
//   bit_cnt       : data bit index
//   strt_chk_en, deser_en, par_chk_en, stop_chk_en : mid-bit checker strobes
//   data_valid    : one-cycle pulse for an accepted frame
//   busy          : high outside IDLE
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            EN,
    input  logic                            rx_in,
    input  logic [PRESC_W-1:0]              prescale,
    input  logic                            par_en,
    input  logic                            strt_glitch,
    input  logic                            par_err,
    input  logic                            stop_err,
    output logic                            data_samp_en,
    output logic [PRESC_W-1:0]              edge_cnt,
    output logic [$clog2(DATA_WIDTH+1)-1:0] bit_cnt,
    output logic                            strt_chk_en,
    output logic                            deser_en,
    output logic                            par_chk_en,
    output logic                            stop_chk_en,
    output logic                            data_valid,
    output logic                            busy
);

    localparam int BIT_W = $clog2(DATA_WIDTH+1);

    rx_state_e          state_q, state_d;
    logic [PRESC_W-1:0] presc_q;
    logic               par_en_q;
    logic               dv_q, dv_d;
    logic               latch_presc, latch_par;
    logic               cnt_clr, edge_run, bit_clr, bit_inc;
    logic               at_mid, at_last;

    assign at_mid  = (edge_cnt == (presc_q >> 1) + PRESC_W'(MID_OFS));
    assign at_last = (edge_cnt == presc_q - PRESC_W'(1));

    always_comb begin
        state_d     = state_q;
        cnt_clr     = 1'b0;
        edge_run    = 1'b0;
        bit_clr     = 1'b0;
        bit_inc     = 1'b0;
        latch_presc = 1'b0;
        latch_par   = 1'b0;
        dv_d        = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (!rx_in) begin
                    state_d     = START;
                    latch_presc = 1'b1;
                end
            end
            START: begin
                edge_run = 1'b1;
                if (at_last) begin
                    state_d = strt_glitch ? IDLE : DATA;
                    bit_clr = 1'b1;
                end
            end
            DATA: begin
                edge_run = 1'b1;
                if (at_last) begin
                    if (bit_cnt == BIT_W'(DATA_WIDTH-1)) begin
                        // par_en is only looked at here; later changes in the
                        // frame do not alter the frame shape or the verdict.
                        state_d   = par_en ? PARITY : STOP;
                        latch_par = 1'b1;
                        bit_clr   = 1'b1;
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end
            PARITY: begin
                edge_run = 1'b1;
                if (at_last)
                    state_d = STOP;
            end
            STOP: begin
                edge_run = 1'b1;
                if (at_last) begin
                    dv_d = !stop_err && !(par_en_q && par_err);
                    // A low line right at the end of the stop bit is the next
                    // start bit: go straight to START without an IDLE cycle.
                    if (!rx_in) begin
                        state_d     = START;
                        latch_presc = 1'b1;
                        cnt_clr     = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (!EN) begin
            state_d     = IDLE;
            cnt_clr     = 1'b1;
            latch_presc = 1'b0;
            latch_par   = 1'b0;
            dv_d        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            par_en_q <= 1'b0;
            dv_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            dv_q    <= dv_d;
            if (latch_presc)
                presc_q <= prescale;
            if (latch_par)
                par_en_q <= par_en;
        end
    end

    uart_edge_bit_cnt #(
        .PRESC_W (PRESC_W),
        .BIT_W   (BIT_W)
    ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (cnt_clr),
        .edge_run  (edge_run),
        .edge_last (at_last),
        .bit_clr   (bit_clr),
        .bit_inc   (bit_inc),
        .edge_cnt  (edge_cnt),
        .bit_cnt   (bit_cnt)
    );

    assign busy         = (state_q != IDLE);
    assign data_samp_en = busy;
    assign strt_chk_en  = EN && (state_q == START)  && at_mid;
    assign deser_en     = EN && (state_q == DATA)   && at_mid;
    assign par_chk_en   = EN && (state_q == PARITY) && at_mid;
    assign stop_chk_en  = EN && (state_q == STOP)   && at_mid;
    assign data_valid   = dv_q;

endmodule
